cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_run_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds the CPU in reset, runs it to a halt instruction, drains, and
// captures probe_data into a FIFO whenever pc hits WATCH_PC. Optional watchdog: MON_TIMEOUT_EN.
module cpu_run_monitor #(
  parameter logic [15:0] WATCH_PC       = 16'h0078,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   instr,
  input  logic [15:0]                   pc,
  input  logic [15:0]                   probe_data,
  input  logic                          pop,
  output logic                          cpu_reset,
  output logic [15:0]                   cap_data,
  output logic                          cap_valid,
  output logic [$clog2(FIFO_DEPTH):0]   cap_count,
  output logic                          overflow,
  output logic                          halted,
  output logic                          done,
  output logic                          timeout
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0]    DEPTH_C    = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    HOLD  = ST_HOLD,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_n;
  logic               r_halted;
  logic               w_halt_set;
  logic               w_halt_instr;
  logic               w_wd_expire;

  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      w_rd_n;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_n;
  logic [15:0]        r_head;
  logic [15:0]        w_head_n;
  logic               r_overflow;
  logic               w_push_req;
  logic               w_do_push;
  logic               w_do_pop;
  logic               w_full;

  assign w_halt_instr = (instr == 16'hE000) || (instr == 16'hE7FF);

`ifdef MON_TIMEOUT_EN
  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_timeout;

  assign w_wd_expire = (r_state == RUN) && (r_tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmr     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == RUN) begin
      r_tmr <= r_tmr + TMR_W'(1);
      // a halt on the expiry cycle wins; the run ended normally
      if (w_wd_expire && !w_halt_instr)
        r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_wd_expire          = 1'b0;
  assign timeout              = 1'b0;
`endif

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_halt_set = 1'b0;
    case (r_state)
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_n = RUN;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (w_halt_instr) begin
          w_state_n  = DRAIN;
          w_cnt_n    = '0;
          w_halt_set = 1'b1;
        end else if (w_wd_expire) begin
          w_state_n = DRAIN;
          w_cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_n = DONE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      DONE:    w_state_n = DONE;
      default: w_state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_halt_set)
        r_halted <= 1'b1;
    end
  end

  assign w_push_req = ((r_state == RUN) || (r_state == DRAIN)) && (pc == WATCH_PC);
  assign w_full     = (r_count == DEPTH_C);
  assign w_do_pop   = pop && (r_count != '0);
  // a full FIFO still accepts a push when the head is leaving on the same edge
  assign w_do_push  = w_push_req && (!w_full || w_do_pop);
  assign w_rd_n     = r_rd_ptr + AW'(w_do_pop);

  always_comb begin
    w_count_n = r_count;
    if (w_do_push && !w_do_pop)
      w_count_n = r_count + CW'(1);
    else if (!w_do_push && w_do_pop)
      w_count_n = r_count - CW'(1);
  end

  // head is registered; bypass the incoming word when it lands in the head slot
  always_comb begin
    w_head_n = r_mem[w_rd_n];
    if (w_count_n == '0)
      w_head_n = '0;
    else if (w_do_push && (r_wr_ptr == w_rd_n))
      w_head_n = probe_data;
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= probe_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      if (w_push_req && w_full && !pop)
        r_overflow <= 1'b1;
    end
  end

  assign cpu_reset = (r_state == HOLD);
  assign done      = (r_state == DONE);
  assign halted    = r_halted;
  assign cap_data  = r_head;
  assign cap_valid = (r_count != '0);
  assign cap_count = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: reset/hold timing, halt and drain, FIFO capture,
// overflow, full push+pop, reset abort and the watchdog (MON_TIMEOUT_EN).
module tb_cpu_run_monitor;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] probe_data;
  logic        pop;
  logic        cpu_reset;
  logic [15:0] cap_data;
  logic        cap_valid;
  logic [4:0]  cap_count;
  logic        overflow;
  logic        halted;
  logic        done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  cpu_run_monitor #(
    .WATCH_PC       (16'h0078),
    .RESET_CYCLES   (4),
    .DRAIN_CYCLES   (10),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc         (pc),
    .probe_data (probe_data),
    .pop        (pop),
    .cpu_reset  (cpu_reset),
    .cap_data   (cap_data),
    .cap_valid  (cap_valid),
    .cap_count  (cap_count),
    .overflow   (overflow),
    .halted     (halted),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; instr = '0; pc = '0; probe_data = '0; pop = 1'b0;
    tick();
    tick();
  endtask

  // releases reset; cpu_reset must stay high 4 cycles, and HOLD must not capture
  task automatic release_hold(input logic [15:0] hold_pc);
    reset = 1'b1;
    pc    = hold_pc;
    probe_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_cpu_reset", cpu_reset, 1);
    end
    tick();
    check("run_cpu_reset", cpu_reset, 0);
    check("hold_no_capture", cap_count, 0);
    pc = '0;
  endtask

  initial begin
    // reset state
    apply_reset();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_cap_count", cap_count, 0);
    check("rst_cap_data", cap_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);

    // halt at 7th RUN cycle, drain 10 cycles
    release_hold(16'h0078);
    for (int i = 0; i < 6; i++) tick();
    check("pre_halt_halted", halted, 0);
    instr = 16'hE000;
    tick();
    instr = '0;
    check("halt_halted", halted, 1);
    check("halt_done", done, 0);
    for (int i = 0; i < 9; i++) tick();
    check("drain9_done", done, 0);
    tick();
    check("drain10_done", done, 1);
    check("done_halted", halted, 1);
    check("done_timeout", timeout, 0);
    pc = 16'h0078; probe_data = 16'h5555;
    tick();
    tick();
    pc = '0;
    check("done_terminal", done, 1);
    check("done_no_capture", cap_count, 0);

    // three captures then three pops
    apply_reset();
    release_hold(16'h0000);
    pc = 16'h0078; probe_data = 16'h0001; tick();
    check("cap1_valid", cap_valid, 1);
    check("cap1_data", cap_data, 16'h0001);
    pc = '0; tick();
    pc = 16'h0078; probe_data = 16'h0002; tick();
    pc = '0; tick();
    pc = 16'h0078; probe_data = 16'h0003; tick();
    pc = '0;
    check("cap3_count", cap_count, 3);
    check("cap3_head", cap_data, 16'h0001);
    pop = 1'b1;
    tick();
    check("pop1_data", cap_data, 16'h0002);
    check("pop1_count", cap_count, 2);
    tick();
    check("pop2_data", cap_data, 16'h0003);
    check("pop2_valid", cap_valid, 1);
    tick();
    check("pop3_valid", cap_valid, 0);
    check("pop3_count", cap_count, 0);
    tick();
    pop = 1'b0;
    check("pop_empty_count", cap_count, 0);
    check("pop_empty_data", cap_data, 0);

    // halt coinciding with a PC match still captures, DRAIN captures too
    pc = 16'h0078; probe_data = 16'hABCD; instr = 16'hE7FF;
    tick();
    instr = '0;
    check("halt_match_halted", halted, 1);
    check("halt_match_count", cap_count, 1);
    check("halt_match_data", cap_data, 16'hABCD);
    probe_data = 16'h1111;
    tick();
    pc = '0;
    check("drain_capture", cap_count, 2);

    // reset mid-DRAIN aborts and restarts HOLD
    reset = 1'b0;
    tick();
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_halted", halted, 0);
    check("abort_count", cap_count, 0);
    check("abort_valid", cap_valid, 0);
    release_hold(16'h0000);

    // 17 pushes without pop: 16 kept, 17th dropped
    apply_reset();
    release_hold(16'h0000);
    pc = 16'h0078;
    for (int i = 0; i < 16; i++) begin
      probe_data = 16'h0100 + 16'(i);
      tick();
    end
    check("fill_count", cap_count, 16);
    check("fill_overflow", overflow, 0);
    probe_data = 16'h0110;
    tick();
    pc = '0;
    check("ovf_count", cap_count, 16);
    check("ovf_overflow", overflow, 1);
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", cap_data, 32'h0100 + 32'(i));
      tick();
    end
    pop = 1'b0;
    check("ovf_drained", cap_count, 0);
    check("ovf_sticky", overflow, 1);

    // full FIFO with push and pop on the same edge
    apply_reset();
    release_hold(16'h0000);
    pc = 16'h0078;
    for (int i = 0; i < 16; i++) begin
      probe_data = 16'h0200 + 16'(i);
      tick();
    end
    check("full_count", cap_count, 16);
    probe_data = 16'h02AA;
    pop = 1'b1;
    tick();
    pc = '0;
    check("pp_count", cap_count, 16);
    check("pp_overflow", overflow, 0);
    check("pp_head", cap_data, 16'h0201);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("pp_order", cap_data, (i < 15) ? 32'h0201 + 32'(i) : 32'h02AA);
    end
    check("pp_last_count", cap_count, 1);
    tick();
    pop = 1'b0;
    check("pp_empty", cap_valid, 0);

    // watchdog
    apply_reset();
    release_hold(16'h0000);
`ifdef MON_TIMEOUT_EN
    for (int i = 0; i < 19; i++) tick();
    check("wd19_timeout", timeout, 0);
    tick();
    check("wd20_timeout", timeout, 1);
    check("wd20_halted", halted, 0);
    check("wd20_done", done, 0);
    for (int i = 0; i < 9; i++) tick();
    check("wd_drain9_done", done, 0);
    tick();
    check("wd_drain10_done", done, 1);
    check("wd_final_timeout", timeout, 1);
    check("wd_final_halted", halted, 0);
`else
    for (int i = 0; i < 35; i++) tick();
    check("nowd_timeout", timeout, 0);
    check("nowd_done", done, 0);
    check("nowd_halted", halted, 0);
    check("nowd_cpu_reset", cpu_reset, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
